// File: rtl/user_io_pkg.sv
// Shared definitions for the user I/O status path: bit map, event field layout, event width.
package user_io_pkg;
  localparam int NUM_STATUS_BITS = 10;

  localparam int MASK_LSB  = 0;
  localparam int STATE_LSB = 10;
  localparam int TS_LSB    = 20;

  localparam int BTN0  = 0;
  localparam int BTN1  = 1;
  localparam int BTN2  = 2;
  localparam int BTN3  = 3;
  localparam int BTN4  = 4;
  localparam int BTN5  = 5;
  localparam int LINK0 = 6;
  localparam int LINK1 = 7;
  localparam int LINK2 = 8;
  localparam int LINK3 = 9;

  function automatic int event_width(input int ts_width);
    return ts_width + 2 * NUM_STATUS_BITS;
  endfunction
endpackage

// File: rtl/event_fifo.sv
// First-word-fall-through FIFO with wrap-bit pointers; a push into a full FIFO is only taken alongside a pop.
module event_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count   = wr_ptr_q - rd_ptr_q;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // When full with a pop, the write slot is the head being read out this cycle.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/user_io_event_queue.sv
// Debounces the 10 poller status bits and queues timestamped change events for the host.
module user_io_event_queue
  import user_io_pkg::*;
#(
  parameter int CLK_RATE_HZ = 16_000_000,
  parameter int DEBOUNCE_MS = 10,
  parameter int FIFO_DEPTH  = 8,
  parameter int TS_WIDTH    = 16
) (
  input  logic                                i_clk,
  input  logic                                i_reset_n,
  input  logic [5:0]                          i_button,
  input  logic [3:0]                          i_link_pow,
  output logic [NUM_STATUS_BITS-1:0]          o_stable,
  output logic [TS_WIDTH+2*NUM_STATUS_BITS-1:0] o_event_data,
  output logic                                o_event_valid,
  input  logic                                i_event_ready,
  output logic [$clog2(FIFO_DEPTH):0]         o_count,
  output logic                                o_overflow,
  input  logic                                i_clear_overflow
);
  localparam int N        = NUM_STATUS_BITS;
  localparam int EW       = event_width(TS_WIDTH);
  localparam int TICK_DIV = CLK_RATE_HZ / 1000;
  localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [1:0]          rst_sync_q;
  logic                rst_n;
  logic [PW-1:0]       presc_q, presc_d;
  logic                tick;
  logic [TS_WIDTH-1:0] ts_q, ts_d;
  logic [N-1:0]        raw;
  logic [N-1:0]        stable_q, stable_d, prev_q, mask;
  logic [N-1:0][7:0]   db_cnt_q, db_cnt_d;
  logic                evt_req_q, evt_req_d;
  logic [EW-1:0]       evt_data_q, evt_data_d;
  logic                ovf_q, ovf_d;
  logic                fifo_full, fifo_empty, drop;

  // Assert asynchronously, release two clocks after i_reset_n rises.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) rst_sync_q <= '0;
    else            rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  always_comb begin
    raw = '0;
    raw[BTN0 +: 6]  = i_button;
    raw[LINK0 +: 4] = i_link_pow;
  end

  assign tick = (presc_q == PW'(TICK_DIV - 1));

  always_comb begin
    presc_d = tick ? '0 : presc_q + PW'(1);
    ts_d    = tick ? ts_q + TS_WIDTH'(1) : ts_q;
  end

  always_comb begin
    stable_d = stable_q;
    db_cnt_d = db_cnt_q;
    for (int i = 0; i < N; i++) begin
      if (raw[i] == stable_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (tick) begin
        if (db_cnt_q[i] == 8'(DEBOUNCE_MS - 1)) begin
          stable_d[i] = raw[i];
          db_cnt_d[i] = '0;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 8'd1;
        end
      end
    end
  end

  assign mask = stable_q ^ prev_q;

  always_comb begin
    evt_req_d                     = |mask;
    evt_data_d                    = '0;
    evt_data_d[MASK_LSB +: N]     = mask;
    evt_data_d[STATE_LSB +: N]    = stable_q;
    evt_data_d[TS_LSB +: TS_WIDTH] = ts_q;
  end

  // A full FIFO always has a head, so only a missing ready loses the event.
  assign drop = evt_req_q && fifo_full && !i_event_ready;

  always_comb begin
    ovf_d = ovf_q;
    if (drop)                  ovf_d = 1'b1;
    else if (i_clear_overflow) ovf_d = 1'b0;
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q    <= '0;
      ts_q       <= '0;
      stable_q   <= '0;
      prev_q     <= '0;
      db_cnt_q   <= '0;
      evt_req_q  <= 1'b0;
      evt_data_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      ts_q       <= ts_d;
      stable_q   <= stable_d;
      prev_q     <= stable_q;
      db_cnt_q   <= db_cnt_d;
      evt_req_q  <= evt_req_d;
      evt_data_q <= evt_data_d;
      ovf_q      <= ovf_d;
    end
  end

  event_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (rst_n),
    .push  (evt_req_q),
    .wdata (evt_data_q),
    .pop   (i_event_ready),
    .rdata (o_event_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (o_count)
  );

  assign o_stable      = stable_q;
  assign o_event_valid = !fifo_empty;
  assign o_overflow    = ovf_q;
endmodule

// File: tb/tb_user_io_event_queue.sv
// Randomized bench for user_io_event_queue against an event-level reference model (queues of events).
module tb_user_io_event_queue;
  localparam int D     = 10;
  localparam int DEPTH = 8;
  localparam int TICK  = 16;

  logic        clk = 1'b0;
  logic        rst_n, rdy, clr;
  logic [5:0]  btn;
  logic [3:0]  lp;
  logic [9:0]  o_stable;
  logic [35:0] o_data;
  logic        o_valid, o_ovf;
  logic [3:0]  o_count;

  always #5 clk = ~clk;

  user_io_event_queue #(
    .CLK_RATE_HZ (16000),
    .DEBOUNCE_MS (D),
    .FIFO_DEPTH  (DEPTH),
    .TS_WIDTH    (16)
  ) dut (
    .i_clk            (clk),
    .i_reset_n        (rst_n),
    .i_button         (btn),
    .i_link_pow       (lp),
    .o_stable         (o_stable),
    .o_event_data     (o_data),
    .o_event_valid    (o_valid),
    .i_event_ready    (rdy),
    .o_count          (o_count),
    .o_overflow       (o_ovf),
    .i_clear_overflow (clr)
  );

  typedef struct {
    int          due;
    logic [35:0] data;
  } pend_t;

  int          n_chk = 0, n_err = 0;
  logic [9:0]  m_stable;
  int          m_dbt [10];
  logic [15:0] m_ts;
  logic        m_ovf;
  int          m_cyc, m_rel;
  pend_t       pq [$];
  logic [35:0] mq [$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_stable = '0;
    foreach (m_dbt[i]) m_dbt[i] = 0;
    m_ts  = '0;
    m_ovf = 1'b0;
    m_cyc = 0;
    m_rel = 0;
    pq.delete();
    mq.delete();
  endtask

  // Stable bit follows raw after D consecutive ms ticks of mismatch; the event reaches the queue two clocks later.
  task automatic model_step();
    logic [9:0] r, flips;
    logic       tick, dropped;
    pend_t      e;
    if (!rst_n) begin
      model_reset();
    end else if (m_rel < 2) begin
      m_rel++;
    end else begin
      if (mq.size() > 0 && rdy) void'(mq.pop_front());
      dropped = 1'b0;
      if (pq.size() > 0 && pq[0].due == m_cyc) begin
        e = pq.pop_front();
        if (mq.size() < DEPTH) mq.push_back(e.data);
        else dropped = 1'b1;
      end
      if (dropped)  m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      tick = ((m_cyc % TICK) == TICK - 1);
      if (tick) m_ts++;
      r = {lp, btn};
      flips = '0;
      for (int i = 0; i < 10; i++) begin
        if (r[i] == m_stable[i]) m_dbt[i] = 0;
        else if (tick) begin
          m_dbt[i]++;
          if (m_dbt[i] == D) begin
            flips[i] = 1'b1;
            m_dbt[i] = 0;
          end
        end
      end
      m_stable = m_stable ^ flips;
      if (flips != '0) begin
        e.due  = m_cyc + 2;
        e.data = {m_ts, m_stable, flips};
        pq.push_back(e);
      end
      m_cyc++;
    end
  endtask

  task automatic compare();
    check("stable", 64'(o_stable), 64'(m_stable));
    check("count", 64'(o_count), 64'(mq.size()));
    check("valid", 64'(o_valid), 64'(mq.size() != 0));
    check("overflow", 64'(o_ovf), 64'(m_ovf));
    if (mq.size() != 0) check("data", 64'(o_data), 64'(mq[0]));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic toggle(input int b);
    logic [9:0] rv;
    rv = {lp, btn};
    rv[b] = ~rv[b];
    {lp, btn} = rv;
  endtask

  initial begin
    rst_n = 1'b0; btn = '0; lp = '0; rdy = 1'b1; clr = 1'b0;
    model_reset();
    run(3);
    check("rst_count", 64'(o_count), 64'd0);
    check("rst_data", 64'(o_data), 64'd0);
    rst_n = 1'b1;
    run(20);

    // Bounce then hold
    for (int k = 0; k < 10; k++) begin
      btn[0] = ~btn[0];
      run(8);
    end
    btn[0] = 1'b1;
    run(250);
    check("bounce_stable", 64'(o_stable), 64'h001);

    // Short glitch on link_pow[1]
    lp[1] = 1'b1;
    run(128);
    lp[1] = 1'b0;
    run(200);
    check("glitch_stable", 64'(o_stable), 64'h001);

    // Two bits together
    btn[2] = 1'b1; lp[3] = 1'b1;
    run(250);
    check("simul_stable", 64'(o_stable), 64'h205);

    // Nine events with host stalled
    rdy = 1'b0;
    for (int k = 0; k < 9; k++) begin
      toggle(k);
      run(200);
    end
    check("ovf_set", 64'(o_ovf), 64'd1);
    check("ovf_count", 64'(o_count), 64'd8);
    rdy = 1'b1;
    run(12);
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    check("ovf_clear", 64'(o_ovf), 64'd0);

    // Full FIFO, event coincides with a pop
    rdy = 1'b0;
    for (int k = 0; k < 8; k++) begin
      toggle(k);
      run(200);
    end
    toggle(9);
    repeat (300) begin
      rdy = (pq.size() > 0 && pq[0].due == m_cyc);
      cycle();
    end
    rdy = 1'b0;
    check("fpp_count", 64'(o_count), 64'd8);
    check("fpp_ovf", 64'(o_ovf), 64'd0);
    rdy = 1'b1;
    run(12);

    // Async reset with events queued and a debounce in flight
    rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      toggle(k);
      run(200);
    end
    toggle(3);
    run(80);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(o_valid), 64'd0);
    check("arst_count", 64'(o_count), 64'd0);
    check("arst_stable", 64'(o_stable), 64'd0);
    model_reset();
    run(3);
    rst_n = 1'b1;
    rdy = 1'b1;
    run(100);
    check("post_rst_count", 64'(o_count), 64'd0);
    run(250);

    // Random traffic with stall windows
    for (int i = 0; i < 8000; i++) begin
      if ($urandom_range(0, 39) == 0) toggle($urandom_range(0, 9));
      if (((i / 1000) % 3) == 2) rdy = 1'b0;
      else rdy = ($urandom_range(0, 7) != 0);
      clr = ($urandom_range(0, 299) == 0);
      cycle();
    end
    clr = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
